// File: rtl/rv_loader_pkg.sv
// rtl/rv_loader_pkg.sv - shared constants and FSM state type for the ICCM loader
package rv_loader_pkg;

  localparam int DEPTH_WORDS_DEF = 256;
  localparam int ADDR_W_DEF      = 8;
  // Width of the little-endian word-count header
  localparam int HDR_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/rv_word_pack.sv
// rtl/rv_word_pack.sv - little-endian byte-to-word assembler with lane counter
module rv_word_pack (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        fire_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] data_q;
  logic [1:0]  lane_q;

  // Word as it stands once the current byte lands in its lane
  always_comb begin
    word_o = data_q;
    case (lane_q)
      2'd0:    word_o[7:0]   = byte_i;
      2'd1:    word_o[15:8]  = byte_i;
      2'd2:    word_o[23:16] = byte_i;
      default: word_o[31:24] = byte_i;
    endcase
  end

  assign word_full_o = fire_i && (lane_q == 2'd3);

  // Lane counter wraps 3->0 on its own, so a full word leaves it ready for the next
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      lane_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      lane_q <= '0;
    end else if (fire_i) begin
      data_q <= word_o;
      lane_q <= lane_q + 2'd1;
    end
  end

endmodule

// File: rtl/rv_iccm_loader.sv
// rtl/rv_iccm_loader.sv - streams a length-prefixed image into the ICCM, then releases the core
module rv_iccm_loader
  import rv_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_no,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [HDR_W:0] DEPTH_L = (HDR_W+1)'(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [HDR_W-1:0]   n_q, n_d;
  logic [HDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [31:0]        mwdata_q, mwdata_d;

  logic               byte_fire;
  logic               start_ok;
  logic [HDR_W-1:0]   hdr_n;
  logic [31:0]        pack_word;
  logic               pack_full;

  assign byte_ready_o = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
  assign byte_fire    = byte_valid_i && byte_ready_o;
  assign start_ok     = start_i &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign hdr_n        = {byte_i, n_q[7:0]};

  rv_word_pack u_pack (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (start_ok),
    .fire_i      (byte_fire && (state_q == ST_DATA)),
    .byte_i      (byte_i),
    .word_o      (pack_word),
    .word_full_o (pack_full)
  );

  // Next-state and counter update; address/data are captured on the 4th byte so they are stable for WRITE
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_HDR0;
          cnt_d   = '0;
          addr_d  = '0;
        end
      end
      ST_HDR0: begin
        if (byte_fire) begin
          n_d[7:0] = byte_i;
          state_d  = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (byte_fire) begin
          n_d = hdr_n;
          if ((hdr_n == '0) || ({1'b0, hdr_n} > DEPTH_L)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pack_full) begin
          state_d  = ST_WRITE;
          maddr_d  = addr_q;
          mwdata_d = pack_word;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q + 16'd1;
        state_d = ((cnt_q + 16'd1) == n_q) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign mem_en_o    = (state_q == ST_WRITE);
  assign mem_we_o    = {4{state_q == ST_WRITE}};
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = mwdata_q;
  assign core_rst_no = (state_q == ST_DONE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_ERR);

endmodule

// File: tb/tb_rv_iccm_loader.sv
// tb/tb_rv_iccm_loader.sv - scoreboard bench for rv_iccm_loader
module tb_rv_iccm_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        core_rst_no;
  logic        done_o;
  logic        err_o;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cycle       = 0;
  int          writes_seen = 0;
  int          last_wr_cyc = 0;
  bit          chk_spacing = 1'b0;
  logic [39:0] exp_q[$];
  logic [31:0] wbuf[256];

  always #5 clk_i = ~clk_i;

  rv_iccm_loader #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .core_rst_no  (core_rst_no),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // One clock; outputs sampled 1 time unit after the edge, every write checked against the scoreboard
  task automatic tick();
    logic [39:0] e;
    @(posedge clk_i);
    #1;
    cycle++;
    if (mem_en_o === 1'b1) begin
      writes_seen++;
      vectors++;
      if (mem_we_o !== 4'hF) begin
        miscompares++;
        $display("FAIL write_we: got %h expected F", mem_we_o);
      end
      vectors++;
      if (byte_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_write: got %b expected 0", byte_ready_o);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%h data=%h expected no write", mem_addr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr_o, mem_wdata_o} !== e) begin
          miscompares++;
          $display("FAIL write_data: got addr=%h data=%h expected addr=%h data=%h",
                   mem_addr_o, mem_wdata_o, e[39:32], e[31:0]);
        end
      end
      if (chk_spacing && writes_seen > 1) begin
        vectors++;
        if (cycle - last_wr_cyc != 5) begin
          miscompares++;
          $display("FAIL write_spacing: got %0d cycles expected 5", cycle - last_wr_cyc);
        end
      end
      last_wr_cyc = cycle;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    bit sent  = 1'b0;
    while (!sent) begin
      byte_i       = b;
      byte_valid_i = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      sent         = byte_valid_i && byte_ready_o;
      tick();
      guard++;
      if (!sent && guard > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL byte_timeout: byte %h not accepted, ready=%b", b, byte_ready_o);
        sent = 1'b1;
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Full load of wbuf[0..n-1]; start_at selects a stream byte during which start_i is held high
  task automatic load(input int n, input bit gaps, input int start_at, input bit do_start);
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(n);
    writes_seen = 0;
    if (do_start) pulse_start();
    send_byte(nn[7:0], gaps);
    send_byte(nn[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = wbuf[i];
      exp_q.push_back({8'(i), w});
      for (int k = 0; k < 4; k++) begin
        start_i = ((i * 4 + k) == start_at);
        send_byte(w[k*8 +: 8], gaps);
        start_i = 1'b0;
      end
    end
    tick();
    vectors++;
    if (done_o !== 1'b1 || core_rst_no !== 1'b1 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL load_done: got done=%b core_rst_n=%b err=%b expected 1 1 0", done_o, core_rst_no, err_o);
    end
    vectors++;
    if (writes_seen != n || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL load_count: got %0d writes, %0d pending expected %0d writes, 0 pending",
               writes_seen, exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    tick();
    tick();
    vectors++;
    if ({byte_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_no, done_o, err_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b en=%b we=%h addr=%h data=%h crst=%b done=%b err=%b expected all 0",
               byte_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_no, done_o, err_o);
    end
    rst_ni = 1'b1;
    tick();
    vectors++;
    if (byte_ready_o !== 1'b0 || core_rst_no !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got rdy=%b crst=%b expected 0 0", byte_ready_o, core_rst_no);
    end
  endtask

  task automatic test_basic();
    wbuf[0] = 32'h1234_5678;
    wbuf[1] = 32'hDEAD_BEEF;
    load(2, 1'b0, -1, 1'b1);
  endtask

  task automatic test_reject(input logic [7:0] lo, input logic [7:0] hi);
    writes_seen = 0;
    pulse_start();
    send_byte(lo, 1'b0);
    send_byte(hi, 1'b0);
    vectors++;
    if (err_o !== 1'b1 || core_rst_no !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_%h%h: got err=%b crst=%b done=%b expected 1 0 0", hi, lo, err_o, core_rst_no, done_o);
    end
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (writes_seen != 0 || err_o !== 1'b1 || byte_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_hold_%h%h: got writes=%0d err=%b rdy=%b expected 0 1 0", hi, lo, writes_seen, err_o, byte_ready_o);
    end
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
    chk_spacing = 1'b1;
    load(256, 1'b0, -1, 1'b1);
    chk_spacing = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (writes_seen != 256 || done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL full_depth_after: got writes=%0d done=%b expected 256 1", writes_seen, done_o);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    load(8, 1'b1, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    writes_seen = 0;
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({byte_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_no, done_o, err_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got rdy=%b en=%b we=%h addr=%h data=%h crst=%b done=%b err=%b expected all 0",
               byte_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, core_rst_no, done_o, err_o);
    end
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (writes_seen != 0 || byte_ready_o !== 1'b0 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_idle: got writes=%0d rdy=%b done=%b expected 0 0 0", writes_seen, byte_ready_o, done_o);
    end
    wbuf[0] = 32'hA5A5_0001;
    wbuf[1] = 32'h0BAD_F00D;
    wbuf[2] = 32'hCAFE_1234;
    load(3, 1'b0, -1, 1'b1);
  endtask

  task automatic test_ignored_start();
    wbuf[0] = 32'h0102_0304;
    wbuf[1] = 32'hF0E0_D0C0;
    load(2, 1'b0, 2, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    vectors++;
    if (core_rst_no !== 1'b0 || done_o !== 1'b0 || byte_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_done: got crst=%b done=%b rdy=%b expected 0 0 1", core_rst_no, done_o, byte_ready_o);
    end
    wbuf[0] = 32'h7777_8888;
    load(1, 1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject(8'h00, 8'h00);
    test_reject(8'h01, 8'h01);
    test_full_depth();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_iccm_loader.md
RV_ICCM_LOADER -- requirements
Module: rv_iccm_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the ICCM depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the ICCM word-address width, equal to clog2(DEPTH_WORDS).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  single-cycle pulse that begins a load.
REQ-006 SHALL have port byte_valid_i  input  1  byte_i carries a valid stream byte.
REQ-007 SHALL have port byte_i  input  8  the stream byte.
REQ-008 SHALL have port byte_ready_o  output  1  the loader accepts byte_i in this cycle.
REQ-009 SHALL have port mem_en_o  output  1  ICCM enable for the write cycle.
REQ-010 SHALL have port mem_we_o  output  4  ICCM byte write enables.
REQ-011 SHALL have port mem_addr_o  output  ADDR_W  ICCM word address.
REQ-012 SHALL have port mem_wdata_o  output  32  ICCM write data.
REQ-013 SHALL have port core_rst_no  output  1  active-low reset driven to the core; 1 releases the core.
REQ-014 SHALL have port done_o  output  1  a load completed successfully.
REQ-015 SHALL have port err_o  output  1  the last load was rejected.

Function
REQ-016 SHALL implement FSM states IDLE, HDR0, HDR1, DATA, WRITE, DONE and ERR.
REQ-017 SHALL transfer a byte only in a cycle where byte_valid_i and byte_ready_o are both 1.
REQ-018 SHALL drive byte_ready_o to 1 in HDR0, HDR1 and DATA only.
REQ-019 SHALL move on start_i from IDLE, DONE or ERR to HDR0, clearing done_o, err_o, the word counter and the address counter.
REQ-020 SHALL ignore start_i in HDR0, HDR1, DATA and WRITE.
REQ-021 SHALL treat the header as a 16-bit little-endian word count N: the HDR0 byte is N[7:0] and the HDR1 byte is N[15:8].
REQ-022 SHALL go from HDR1 to ERR when N == 0 or N > DEPTH_WORDS, evaluated on the HDR1 transfer; otherwise it SHALL go to DATA.
REQ-023 SHALL assemble four DATA bytes little-endian (first byte into bits [7:0]); on the 4th transfer it SHALL go to WRITE.
REQ-024 SHALL, in WRITE (exactly one cycle), drive mem_en_o=1, mem_we_o=4'hF, mem_addr_o=the address counter and mem_wdata_o=the assembled word.
REQ-025 SHALL, when leaving WRITE, increment the address counter and the word counter, then go to DONE if the word count equals N, else to DATA.
REQ-026 SHALL drive mem_en_o=0 and mem_we_o=4'h0 outside WRITE, with mem_addr_o and mem_wdata_o holding their last values.
REQ-027 SHALL hold core_rst_no=0 in every state except DONE, and drive it to 1 in DONE.
REQ-028 SHALL drive done_o=1 only in DONE and err_o=1 only in ERR.
REQ-029 SHALL, at N == DEPTH_WORDS, write the last word to address DEPTH_WORDS-1 and SHALL NOT wrap the address to 0 as a write.
REQ-030 SHALL give a throughput of 5 cycles per word at an always-valid stream (4 byte cycles plus 1 write cycle).
REQ-031 SHALL hold its state with no transfer while byte_valid_i=0.

Reset
REQ-032 SHALL, on rst_ni=0 at any time including mid-load, enter IDLE asynchronously.
REQ-033 SHALL reset these outputs: byte_ready_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_no=0, done_o=0, err_o=0.
REQ-034 SHALL reset the counters and the assembly register to 0; partial words are discarded and never written.

Structure
REQ-035 SHALL place the state enum, DEPTH_WORDS default, ADDR_W default and the 16-bit header width constant in the shared package rv_loader_pkg.
REQ-036 SHALL contain one sub-module, rv_word_pack, which holds the byte-to-word little-endian assembler and the byte-lane counter (0..3) with a word_full strobe.

Verification
REQ-037 SHALL verify basic load: start, then 02 00, then 78 56 34 12 EF BE AD DE -> writes of 0x12345678 at address 0 and 0xDEADBEEF at address 1, each with mem_we_o=F for one cycle; then done_o=1 and core_rst_no=1.
REQ-038 SHALL verify rejection: header 00 00, then separately header 01 01 (N=257) -> ERR each time, err_o=1, core_rst_no=0, no mem_en_o pulse.
REQ-039 SHALL verify full depth: N=256 with an always-valid stream -> 256 writes on addresses 0..255 in order, 5-cycle spacing, done_o after the write to address 255, no write to address 0 after that.
REQ-040 SHALL verify back-pressure: byte_valid_i toggled randomly -> write data identical to the no-gap case; byte_ready_o=0 during every WRITE cycle.
REQ-041 SHALL verify reset mid-word: rst_ni pulsed low after 2 DATA bytes -> IDLE, all outputs at reset values, no write; a following clean load succeeds.
REQ-042 SHALL verify ignored start: start_i pulsed in DATA -> load continues unchanged; start_i in DONE -> core_rst_no falls to 0 in the next cycle and a new load begins.
